// File: rtl/wb_pkg.sv
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared widths for the writeback arbitration slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package wb_pkg;
    localparam int NUM_WB_SLOTS = 2;
    localparam int SID_W_DEF    = `SCOREBOARD_SIZE_WIDTH;
    localparam int RD_W         = 5;
    localparam int XLEN         = 64;
    localparam int INST_W       = 32;
endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module  : rr_pick2
// Brief   : Finds the first two set bits of a vector, scanning from a
//           round-robin pointer and wrapping modulo NUM_SRC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick2 #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_a_idx,
    output logic               o_a_vld,
    output logic [PTR_W-1:0]   o_b_idx,
    output logic               o_b_vld
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_a_idx = '0;
        o_a_vld = 1'b0;
        o_b_idx = '0;
        o_b_vld = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // One extra bit keeps ptr+i exact so the wrap works for any NUM_SRC.
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_SRC);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (i_valid[w_idx]) begin
                if (!o_a_vld) begin
                    o_a_vld = 1'b1;
                    o_a_idx = w_idx;
                end else if (!o_b_vld) begin
                    o_b_vld = 1'b1;
                    o_b_idx = w_idx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module  : wb_arbiter
// Brief   : Buffers one result per execution unit and grants up to two per
//           cycle to the writeback slots, oldest scoreboard id in slot0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SID_W   = `SCOREBOARD_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    input  logic [NUM_SRC*RD_W-1:0]   src_rd_i,
    input  logic [NUM_SRC*XLEN-1:0]   src_value_i,
    input  logic [NUM_SRC*XLEN-1:0]   src_pc_i,
    input  logic [NUM_SRC*INST_W-1:0] src_inst_i,
    input  logic [NUM_SRC-1:0]        src_redirect_i,
    input  logic [NUM_SRC*XLEN-1:0]   src_redirect_pc_i,
    input  logic [NUM_SRC*SID_W-1:0]  src_sid_i,
    input  logic [SID_W-1:0]          sb_head_sid_i,
    input  logic                      flush_i,
    output logic                      slot0_valid_o,
    output logic [RD_W-1:0]           slot0_rd_o,
    output logic [XLEN-1:0]           slot0_value_o,
    output logic [XLEN-1:0]           slot0_pc_o,
    output logic [INST_W-1:0]         slot0_inst_o,
    output logic                      slot0_redirect_o,
    output logic [XLEN-1:0]           slot0_redirect_pc_o,
    output logic [SID_W-1:0]          slot0_sid_o,
    output logic                      slot1_valid_o,
    output logic [RD_W-1:0]           slot1_rd_o,
    output logic [XLEN-1:0]           slot1_value_o,
    output logic [XLEN-1:0]           slot1_pc_o,
    output logic [INST_W-1:0]         slot1_inst_o,
    output logic                      slot1_redirect_o,
    output logic [XLEN-1:0]           slot1_redirect_pc_o,
    output logic [SID_W-1:0]          slot1_sid_o
);

    localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] r_buf_vld;
    logic [NUM_SRC-1:0] r_buf_red;
    logic [RD_W-1:0]    r_buf_rd    [NUM_SRC];
    logic [XLEN-1:0]    r_buf_value [NUM_SRC];
    logic [XLEN-1:0]    r_buf_pc    [NUM_SRC];
    logic [INST_W-1:0]  r_buf_inst  [NUM_SRC];
    logic [XLEN-1:0]    r_buf_rpc   [NUM_SRC];
    logic [SID_W-1:0]   r_buf_sid   [NUM_SRC];
    logic [c_PTR_W-1:0] r_rr_ptr;

    logic [SID_W-1:0]        w_buf_age [NUM_SRC];
    logic [SID_W-1:0]        w_in_age  [NUM_SRC];
    logic [c_PTR_W-1:0]      w_a_idx, w_b_idx, w_last, w_next_ptr;
    logic                    w_a_vld, w_b_vld, w_swap;
    logic [c_PTR_W-1:0]      w_slot_idx [NUM_WB_SLOTS];
    logic [NUM_WB_SLOTS-1:0] w_slot_pick;
    logic [NUM_WB_SLOTS-1:0] w_slot_out;
    logic                    w_red0, w_red1, w_sq_en;
    logic [SID_W-1:0]        w_sq_age;
    logic [NUM_SRC-1:0]      w_grant, w_squash, w_accept;

    rr_pick2 #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .i_valid (r_buf_vld),
        .i_ptr   (r_rr_ptr),
        .o_a_idx (w_a_idx),
        .o_a_vld (w_a_vld),
        .o_b_idx (w_b_idx),
        .o_b_vld (w_b_vld)
    );

    // Ages are distances from the scoreboard head, so wrap-around sids order correctly.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            w_buf_age[k] = r_buf_sid[k] - sb_head_sid_i;
            w_in_age[k]  = src_sid_i[k*SID_W +: SID_W] - sb_head_sid_i;
        end
    end

    always_comb begin
        w_swap        = w_b_vld && (w_buf_age[w_b_idx] < w_buf_age[w_a_idx]);
        w_slot_idx[0] = w_swap ? w_b_idx : w_a_idx;
        w_slot_idx[1] = w_swap ? w_a_idx : w_b_idx;
        w_slot_pick   = {w_b_vld & ~flush_i, w_a_vld & ~flush_i};
        w_red0        = w_slot_pick[0] & r_buf_red[w_slot_idx[0]];
        w_red1        = w_slot_pick[1] & r_buf_red[w_slot_idx[1]] & ~w_red0;
        w_sq_en       = w_red0 | w_red1;
        w_sq_age      = w_red0 ? w_buf_age[w_slot_idx[0]] : w_buf_age[w_slot_idx[1]];
        w_slot_out    = {w_slot_pick[1] & ~w_red0, w_slot_pick[0]};
    end

    always_comb begin
        w_grant     = '0;
        w_squash    = '0;
        w_accept    = '0;
        src_ready_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // A grant suppressed by a slot0 redirect still frees its buffer.
            w_grant[k]     = (w_slot_pick[0] && (w_slot_idx[0] == c_PTR_W'(k)))
                          || (w_slot_pick[1] && (w_slot_idx[1] == c_PTR_W'(k)));
            w_squash[k]    = w_sq_en && r_buf_vld[k] && !w_grant[k] && (w_buf_age[k] > w_sq_age);
            src_ready_o[k] = !r_buf_vld[k] || w_grant[k] || w_squash[k] || flush_i;
            w_accept[k]    = src_valid_i[k] && src_ready_o[k] && !flush_i
                          && !(w_sq_en && (w_in_age[k] > w_sq_age));
        end
    end

    assign w_last     = w_b_vld ? w_b_idx : w_a_idx;
    assign w_next_ptr = (w_last == c_PTR_W'(NUM_SRC-1)) ? '0 : w_last + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= '0;
            r_rr_ptr  <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (w_accept[k]) begin
                    r_buf_vld[k] <= 1'b1;
                end else if (flush_i || w_grant[k] || w_squash[k]) begin
                    r_buf_vld[k] <= 1'b0;
                end
            end
            if (!flush_i && w_a_vld) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    // Payload is only observed while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_accept[k]) begin
                r_buf_red[k]   <= src_redirect_i[k];
                r_buf_rd[k]    <= src_rd_i[k*RD_W +: RD_W];
                r_buf_value[k] <= src_value_i[k*XLEN +: XLEN];
                r_buf_pc[k]    <= src_pc_i[k*XLEN +: XLEN];
                r_buf_inst[k]  <= src_inst_i[k*INST_W +: INST_W];
                r_buf_rpc[k]   <= src_redirect_pc_i[k*XLEN +: XLEN];
                r_buf_sid[k]   <= src_sid_i[k*SID_W +: SID_W];
            end
        end
    end

    assign slot0_valid_o       = w_slot_out[0];
    assign slot0_rd_o          = w_slot_out[0] ? r_buf_rd[w_slot_idx[0]]    : '0;
    assign slot0_value_o       = w_slot_out[0] ? r_buf_value[w_slot_idx[0]] : '0;
    assign slot0_pc_o          = w_slot_out[0] ? r_buf_pc[w_slot_idx[0]]    : '0;
    assign slot0_inst_o        = w_slot_out[0] ? r_buf_inst[w_slot_idx[0]]  : '0;
    assign slot0_redirect_o    = w_slot_out[0] & r_buf_red[w_slot_idx[0]];
    assign slot0_redirect_pc_o = w_slot_out[0] ? r_buf_rpc[w_slot_idx[0]]   : '0;
    assign slot0_sid_o         = w_slot_out[0] ? r_buf_sid[w_slot_idx[0]]   : '0;

    assign slot1_valid_o       = w_slot_out[1];
    assign slot1_rd_o          = w_slot_out[1] ? r_buf_rd[w_slot_idx[1]]    : '0;
    assign slot1_value_o       = w_slot_out[1] ? r_buf_value[w_slot_idx[1]] : '0;
    assign slot1_pc_o          = w_slot_out[1] ? r_buf_pc[w_slot_idx[1]]    : '0;
    assign slot1_inst_o        = w_slot_out[1] ? r_buf_inst[w_slot_idx[1]]  : '0;
    assign slot1_redirect_o    = w_slot_out[1] & r_buf_red[w_slot_idx[1]];
    assign slot1_redirect_pc_o = w_slot_out[1] ? r_buf_rpc[w_slot_idx[1]]   : '0;
    assign slot1_sid_o         = w_slot_out[1] ? r_buf_sid[w_slot_idx[1]]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Self-checking bench for wb_arbiter against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int SID_W   = 4;
    localparam int SLOT_W  = 235;
    localparam int OBS_W   = 2*SLOT_W + NUM_SRC;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_SRC-1:0]       src_valid, src_ready, src_redirect;
    logic [NUM_SRC*5-1:0]     src_rd;
    logic [NUM_SRC*64-1:0]    src_value, src_pc, src_rpc;
    logic [NUM_SRC*32-1:0]    src_inst;
    logic [NUM_SRC*SID_W-1:0] src_sid;
    logic [SID_W-1:0]         sb_head;
    logic                     flush;
    logic                     slot0_valid_o, slot0_redirect_o, slot1_valid_o, slot1_redirect_o;
    logic [4:0]               slot0_rd_o, slot1_rd_o;
    logic [63:0]              slot0_value_o, slot0_pc_o, slot0_redirect_pc_o;
    logic [63:0]              slot1_value_o, slot1_pc_o, slot1_redirect_pc_o;
    logic [31:0]              slot0_inst_o, slot1_inst_o;
    logic [SID_W-1:0]         slot0_sid_o, slot1_sid_o;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_SRC(NUM_SRC), .SID_W(SID_W)) dut (
        .clk(clk), .rst(rst),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_rd_i(src_rd), .src_value_i(src_value), .src_pc_i(src_pc),
        .src_inst_i(src_inst), .src_redirect_i(src_redirect),
        .src_redirect_pc_i(src_rpc), .src_sid_i(src_sid),
        .sb_head_sid_i(sb_head), .flush_i(flush),
        .slot0_valid_o(slot0_valid_o), .slot0_rd_o(slot0_rd_o), .slot0_value_o(slot0_value_o),
        .slot0_pc_o(slot0_pc_o), .slot0_inst_o(slot0_inst_o), .slot0_redirect_o(slot0_redirect_o),
        .slot0_redirect_pc_o(slot0_redirect_pc_o), .slot0_sid_o(slot0_sid_o),
        .slot1_valid_o(slot1_valid_o), .slot1_rd_o(slot1_rd_o), .slot1_value_o(slot1_value_o),
        .slot1_pc_o(slot1_pc_o), .slot1_inst_o(slot1_inst_o), .slot1_redirect_o(slot1_redirect_o),
        .slot1_redirect_pc_o(slot1_redirect_pc_o), .slot1_sid_o(slot1_sid_o)
    );

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [63:0] val;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        red;
        logic [63:0] rpc;
        logic [3:0]  sid;
    } ent_t;

    ent_t             m_buf [NUM_SRC];
    int               m_ptr;
    int               m_picks[$];
    int               m_s0, m_s1;
    bit               m_red_on;
    logic [3:0]       m_red_age;
    bit [NUM_SRC-1:0] m_leave;
    logic [NUM_SRC-1:0] exp_ready;
    logic [OBS_W-1:0] exp_obs, obs;

    int vectors = 0;
    int miscompares = 0;
    int seq = 0;
    int cyc = 0;

    function automatic logic [3:0] age_of(logic [3:0] sid);
        return sid - sb_head;
    endfunction

    function automatic logic [SLOT_W-1:0] mslot(int idx);
        if (idx < 0) return '0;
        return {1'b1, m_buf[idx].rd, m_buf[idx].val, m_buf[idx].pc, m_buf[idx].inst,
                m_buf[idx].red, m_buf[idx].rpc, m_buf[idx].sid};
    endfunction

    function automatic logic [OBS_W-1:0] get_obs();
        return {slot0_valid_o, slot0_rd_o, slot0_value_o, slot0_pc_o, slot0_inst_o,
                slot0_redirect_o, slot0_redirect_pc_o, slot0_sid_o,
                slot1_valid_o, slot1_rd_o, slot1_value_o, slot1_pc_o, slot1_inst_o,
                slot1_redirect_o, slot1_redirect_pc_o, slot1_sid_o, src_ready};
    endfunction

    // Expected outputs for this cycle from the arbitration rules.
    task automatic model_eval();
        int a, b;
        m_picks.delete();
        for (int i = 0; i < NUM_SRC; i++) begin
            int k = (m_ptr + i) % NUM_SRC;
            if (m_buf[k].v && m_picks.size() < 2) m_picks.push_back(k);
        end
        m_s0 = -1; m_s1 = -1; m_red_on = 0; m_red_age = '0; m_leave = '0;
        if (!flush && m_picks.size() > 0) begin
            a = m_picks[0];
            b = (m_picks.size() > 1) ? m_picks[1] : -1;
            m_leave[a] = 1'b1;
            if (b >= 0) m_leave[b] = 1'b1;
            if (b >= 0 && age_of(m_buf[b].sid) < age_of(m_buf[a].sid)) begin
                m_s0 = b; m_s1 = a;
            end else begin
                m_s0 = a; m_s1 = b;
            end
            if (m_buf[m_s0].red) begin
                m_red_on = 1; m_red_age = age_of(m_buf[m_s0].sid); m_s1 = -1;
            end else if (m_s1 >= 0 && m_buf[m_s1].red) begin
                m_red_on = 1; m_red_age = age_of(m_buf[m_s1].sid);
            end
            if (m_red_on)
                for (int k = 0; k < NUM_SRC; k++)
                    if (m_buf[k].v && age_of(m_buf[k].sid) > m_red_age) m_leave[k] = 1'b1;
        end
        for (int k = 0; k < NUM_SRC; k++) exp_ready[k] = flush || !m_buf[k].v || m_leave[k];
        exp_obs = {mslot(m_s0), mslot(m_s1), exp_ready};
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int k = 0; k < NUM_SRC; k++) m_buf[k].v = 0;
            m_ptr = 0;
        end else if (flush) begin
            for (int k = 0; k < NUM_SRC; k++) m_buf[k].v = 0;
        end else begin
            if (m_picks.size() > 0) m_ptr = (m_picks[m_picks.size()-1] + 1) % NUM_SRC;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (m_leave[k]) m_buf[k].v = 0;
                if (src_valid[k] && exp_ready[k] &&
                    !(m_red_on && age_of(src_sid[k*4 +: 4]) > m_red_age)) begin
                    m_buf[k].v    = 1;
                    m_buf[k].rd   = src_rd[k*5 +: 5];
                    m_buf[k].val  = src_value[k*64 +: 64];
                    m_buf[k].pc   = src_pc[k*64 +: 64];
                    m_buf[k].inst = src_inst[k*32 +: 32];
                    m_buf[k].red  = src_redirect[k];
                    m_buf[k].rpc  = src_rpc[k*64 +: 64];
                    m_buf[k].sid  = src_sid[k*4 +: 4];
                end
            end
        end
    endtask

    task automatic clear_inputs();
        src_valid = '0;
        src_redirect = '0;
        flush = 1'b0;
    endtask

    task automatic set_src(input int k, input logic [3:0] sid, input logic red, input logic [63:0] rpc);
        src_valid[k]          = 1'b1;
        src_rd[k*5 +: 5]      = 5'($urandom);
        src_value[k*64 +: 64] = {$urandom, $urandom};
        src_pc[k*64 +: 64]    = {4'(k), 28'h0, 32'(seq)};
        src_inst[k*32 +: 32]  = $urandom;
        src_redirect[k]       = red;
        src_rpc[k*64 +: 64]   = rpc;
        src_sid[k*4 +: 4]     = sid;
        seq++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sb_head = '0; clear_inputs();
        src_rd = '0; src_value = '0; src_pc = '0; src_inst = '0; src_rpc = '0; src_sid = '0;
        for (int k = 0; k < NUM_SRC; k++) m_buf[k].v = 0;
        m_ptr = 0;
        repeat (2) begin settle(); advance(); end
        rst = 1'b0;
        repeat (2) begin
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            vectors++;
            if ({slot0_valid_o, slot1_valid_o, src_ready} !== {2'b00, 4'hF}) begin
                miscompares++;
                $display("FAIL reset_idle got=%b%b/%h exp=00/f", slot0_valid_o, slot1_valid_o, src_ready);
            end
            advance();
        end
    endtask

    task automatic test_order();
        clear_inputs(); sb_head = 4'd0;
        set_src(0, 4'd3, 1'b0, '0); set_src(1, 4'd1, 1'b0, '0); set_src(2, 4'd2, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL order cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (c == 1) begin
                vectors++;
                if ({slot0_valid_o, slot0_sid_o, slot0_pc_o[63:60], slot1_valid_o, slot1_sid_o, slot1_pc_o[63:60]}
                    !== {1'b1, 4'd1, 4'd1, 1'b1, 4'd3, 4'd0}) begin
                    miscompares++;
                    $display("FAIL order_pair got=s0 sid%0d src%0d s1 v%b sid%0d src%0d exp=s0 sid1 src1 s1 v1 sid3 src0",
                             slot0_sid_o, slot0_pc_o[63:60], slot1_valid_o, slot1_sid_o, slot1_pc_o[63:60]);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({slot0_valid_o, slot0_pc_o[63:60], slot1_valid_o} !== {1'b1, 4'd2, 1'b0}) begin
                    miscompares++;
                    $display("FAIL order_next got=v%b src%0d s1v%b exp=v1 src2 s1v0",
                             slot0_valid_o, slot0_pc_o[63:60], slot1_valid_o);
                end
            end
            advance();
            clear_inputs();
        end
    endtask

    task automatic test_age_wrap();
        clear_inputs(); sb_head = 4'd14;
        set_src(0, 4'd1, 1'b0, '0); set_src(1, 4'd15, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL age_wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (c == 1) begin
                vectors++;
                if ({slot0_valid_o, slot0_sid_o, slot1_valid_o, slot1_sid_o} !== {1'b1, 4'd15, 1'b1, 4'd1}) begin
                    miscompares++;
                    $display("FAIL age_wrap_order got=s0 sid%0d s1 sid%0d exp=s0 sid15 s1 sid1", slot0_sid_o, slot1_sid_o);
                end
            end
            advance();
            clear_inputs();
        end
    endtask

    task automatic test_redirect();
        clear_inputs(); sb_head = 4'd0;
        set_src(0, 4'd0, 1'b0, '0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                set_src(0, 4'd4, 1'b0, '0);
                set_src(1, 4'd2, 1'b1, 64'h8000_0100);
                set_src(3, 4'd5, 1'b0, '0);
            end
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (c == 3) begin
                vectors++;
                if ({slot0_valid_o, slot0_redirect_o, slot0_redirect_pc_o, slot0_sid_o, slot1_valid_o}
                    !== {1'b1, 1'b1, 64'h8000_0100, 4'd2, 1'b0}) begin
                    miscompares++;
                    $display("FAIL redirect_slot got=v%b r%b pc%h sid%0d s1v%b exp=v1 r1 pc0000000080000100 sid2 s1v0",
                             slot0_valid_o, slot0_redirect_o, slot0_redirect_pc_o, slot0_sid_o, slot1_valid_o);
                end
            end
            if (c > 3) begin
                vectors++;
                if ({slot0_valid_o, slot1_valid_o} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL redirect_squash got=%b%b exp=00", slot0_valid_o, slot1_valid_o);
                end
            end
            advance();
            clear_inputs();
        end
    endtask

    task automatic test_flush();
        clear_inputs(); sb_head = 4'd0;
        set_src(0, 4'd1, 1'b0, '0); set_src(1, 4'd2, 1'b0, '0); set_src(3, 4'd3, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                flush = 1'b1;
                set_src(2, 4'd4, 1'b0, '0);
            end
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL flush cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (c == 1) begin
                vectors++;
                if ({slot0_valid_o, slot1_valid_o, src_ready} !== {2'b00, 4'hF}) begin
                    miscompares++;
                    $display("FAIL flush_cycle got=%b%b/%h exp=00/f", slot0_valid_o, slot1_valid_o, src_ready);
                end
            end
            if (c > 1) begin
                vectors++;
                if ({slot0_valid_o, slot1_valid_o} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL flush_after got=%b%b exp=00", slot0_valid_o, slot1_valid_o);
                end
            end
            advance();
            clear_inputs();
        end
    endtask

    task automatic test_back_to_back();
        int last_g;
        last_g = 0;
        sb_head = 4'($urandom);
        for (int c = 0; c < 12; c++) begin
            clear_inputs();
            if (c <= 8)
                for (int k = 0; k < NUM_SRC; k++) set_src(k, 4'($urandom), 1'b0, '0);
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if ((slot0_valid_o && slot0_pc_o[63:60] == 4'd0) || (slot1_valid_o && slot1_pc_o[63:60] == 4'd0))
                last_g = c;
            if (c >= 2 && c <= 9) begin
                vectors++;
                if (last_g < c - 1) begin
                    miscompares++;
                    $display("FAIL fairness c=%0d got=last src0 grant at %0d exp=within 2 cycles", c, last_g);
                end
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) sb_head = 4'($urandom);
            for (int k = 0; k < NUM_SRC; k++)
                if ($urandom_range(0, 1) == 1)
                    set_src(k, 4'($urandom), ($urandom_range(0, 7) == 0), {$urandom, $urandom});
            settle();
            obs = get_obs(); vectors++;
            if (obs !== exp_obs) begin
                miscompares++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            advance();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_order();
        test_age_wrap();
        test_redirect();
        test_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the two writeback slots (inst0/inst1) among NUM_SRC execution-unit result sources (ALU0, ALU1, MUL/DIV, LSU).
- Each source has a one-entry holding buffer. Up to two buffered results are granted per cycle in round-robin order.
- Granted results are age-ordered so slot0 always carries the older scoreboard id. This makes the writeback stage's slot0-first redirect priority correct.
- On a granted redirect, younger results are squashed. Sits between the execution units and the writeback stage.

Parameters:
- NUM_SRC, 4, number of result sources.
- SID_W, `SCOREBOARD_SIZE_WIDTH, scoreboard id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_valid_i  in  NUM_SRC  per-source result valid
- src_ready_o  out  NUM_SRC  per-source buffer can accept
- src_rd_i  in  NUM_SRC*5  destination register
- src_value_i  in  NUM_SRC*64  result value
- src_pc_i  in  NUM_SRC*64  instruction pc
- src_inst_i  in  NUM_SRC*32  instruction word
- src_redirect_i  in  NUM_SRC  result requests redirect
- src_redirect_pc_i  in  NUM_SRC*64  redirect target
- src_sid_i  in  NUM_SRC*SID_W  scoreboard id
- sb_head_sid_i  in  SID_W  oldest in-flight sid (age origin)
- flush_i  in  1  external pipeline flush
- slotN_valid_o, slotN_rd_o(5), slotN_value_o(64), slotN_pc_o(64), slotN_inst_o(32), slotN_redirect_o(1), slotN_redirect_pc_o(64), slotN_sid_o(SID_W)  out  N=0,1; slot outputs to writeback stage inst0/inst1 inputs

Behaviour:
- Reset: all buffers invalid; rr_ptr=0; src_ready_o=all 1s; slot valid/redirect outputs 0; slot data outputs 0.
- Reset takes priority over all other inputs. A reset mid-operation discards all buffered results.
- Accept:
  - src_ready_o[k] = buffer k empty, or buffer k granted this cycle, or buffer k squashed this cycle.
  - Result is captured at the edge where src_valid_i[k] && src_ready_o[k].
  - src_ready_o does not depend on src_valid_i.
- Latency: a result captured at edge N is eligible on the slot outputs in cycle N+1. Slot outputs are combinational from the buffer registers; there is no further register.
- Grant:
  - Scan buffers starting at rr_ptr, wrapping modulo NUM_SRC.
  - The first valid buffer is pick A; the next valid buffer is pick B.
  - 0, 1 or 2 grants per cycle.
  - If no buffer is valid, rr_ptr holds.
  - Otherwise rr_ptr = (index of last granted buffer + 1) mod NUM_SRC, even if that grant is suppressed by squash.
- Age:
  - age(x) = (sid(x) - sb_head_sid_i) mod 2^SID_W, unsigned, SID_W bits wide.
  - Smaller age = older.
- Ordering: the older of A and B drives slot0, the other drives slot1. On equal ages A goes to slot0. With one grant, slot0 carries it and slot1_valid_o=0.
- Redirect squash:
  - If slot0 carries a redirect: slot1_valid_o is forced 0, and its buffer is cleared without writeback.
  - Also at that edge:
    - every other valid buffer with age > slot0 age is cleared;
    - incoming accepts with age > slot0 age are dropped, with ready still asserted.
  - If only slot1 redirects: the same rule applies with slot1's age; slot0 is unaffected.
  - Granted buffers are cleared at the edge.
- flush_i:
  - slot valid outputs forced 0 in the same cycle.
  - All buffers cleared at the edge.
  - No grants; rr_ptr holds; src_ready_o=all 1s with incoming results discarded.
  - flush_i wins over a simultaneous redirect.
- Simultaneous accept and grant on the same buffer: the new entry is written; the granted entry leaves.
- Bus slicing: source k occupies bits [k*W +: W] of each packed bus.

Decomposition:
- Shared package (wb_pkg), constants only:
  - NUM_WB_SLOTS=2;
  - the SCOREBOARD_SIZE_WIDTH define reuse;
  - result-record field widths (RD_W=5, XLEN=64, INST_W=32).
- Sub-module rr_pick2: a combinational round-robin scanner. Inputs: valid vector, rr_ptr. Outputs: picks A/B indices plus valid flags. Keeps the arbiter top readable.

Test Plan:
- Reset, then idle: slot0/1_valid_o=0, src_ready_o=4'b1111, rr_ptr=0.
- Sources 0,1,2 valid together, head=0, sids 3,1,2:
  - Cycle 1: grants src0, src1; slot0 sid 1 (src1), slot1 sid 3 (src0); rr_ptr becomes 2.
  - Cycle 2: slot0 = src2.
- Age wrap, SID_W=4, head=14, sid 15 and sid 1 granted together: slot0 sid 15, slot1 sid 1.
- src1 sid 2 with redirect pc 0x8000_0100, src3 sid 5 granted together, src0 buffered with sid 4, head=0:
  - slot0 redirect to 0x8000_0100 is presented; slot1_valid_o=0.
  - Buffers 3 and 0 are cleared; neither ever appears on a slot.
- flush_i with 3 buffers full and a new src2 valid: slots invalid that cycle; next cycle all buffers empty and nothing is emitted.
- Back-pressure: src0 valid every cycle for 8 cycles while sources 1–3 stay full and valid. src0 is granted at least once in every 2 consecutive cycles (round-robin fairness), and no result is lost or duplicated.
